// File: rtl/lsq_mem_pkg.sv
// Shared constants, encodings and types for the data memory responder
// and its request buffer.
package lsq_mem_pkg;

  localparam int unsigned DEF_MEM_BYTES   = 1024;
  localparam int unsigned DEF_MEM_LATENCY = 4;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROB_W  = 6;

  localparam logic LS_LOAD  = 1'b1;
  localparam logic LS_STORE = 1'b0;
  localparam logic BMS_BYTE = 1'b1;
  localparam logic BMS_WORD = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic              ls;
    logic              bms;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store_value;
    logic [ROB_W-1:0]  rob_index;
  } mem_req_t;

  function automatic logic [DATA_W-1:0] sext_byte(input logic [7:0] b);
    return {{(DATA_W - 8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load-store queue (master) and the
// data memory responder (slave).
interface data_mem_responder_if;
  import lsq_mem_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_LS;
  logic              mem_BMS;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_store_value;
  logic [ROB_W-1:0]  mem_ROB_index;

  logic              mem_valid_out;
  logic              mem_LS_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_load_value_out;
  logic [ROB_W-1:0]  mem_ROB_index_out;

  modport master (
    output mem_valid, mem_LS, mem_BMS, mem_address, mem_store_value, mem_ROB_index,
    input  mem_ready, mem_valid_out, mem_LS_out, mem_addr_out, mem_load_value_out,
           mem_ROB_index_out
  );

  modport slave (
    input  mem_valid, mem_LS, mem_BMS, mem_address, mem_store_value, mem_ROB_index,
    output mem_ready, mem_valid_out, mem_LS_out, mem_addr_out, mem_load_value_out,
           mem_ROB_index_out
  );

endinterface

// File: rtl/mem_req_fifo.sv
// Pending-request buffer: first-word-fall-through FIFO of request records.
// Simultaneous push and pop both take effect and leave the count unchanged.
module mem_req_fifo
  import lsq_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  mem_req_t i_data,
  input  logic     i_pop,
  output mem_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  mem_req_t      r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FullCnt);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency byte-addressed data memory serving buffered load/store requests
// strictly in order, one response pulse per request. MEM_BYTES must be a power of two.
module data_mem_responder
  import lsq_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = DEF_MEM_BYTES,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave mem_if
);

  localparam int unsigned AW   = $clog2(MEM_BYTES);
  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

  mem_state_e r_state;
  mem_state_e w_next_state;

  mem_req_t   w_req;
  mem_req_t   w_head;
  mem_req_t   r_cur;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_access;
  logic       w_valid_out;

  logic [CntW-1:0]   r_cnt;
  logic              r_ls_out;
  logic [ADDR_W-1:0] r_addr_out;
  logic [DATA_W-1:0] r_load_out;
  logic [ROB_W-1:0]  r_rob_out;

  // Contents survive reset; only the access pipeline is cleared.
  logic [7:0]        r_mem [MEM_BYTES];
  logic [AW-1:0]     w_byte_idx;
  logic [AW-3:0]     w_word_base;
  logic [7:0]        w_rd_byte;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_load_value;

  assign w_req = '{
    ls:          mem_if.mem_LS,
    bms:         mem_if.mem_BMS,
    addr:        mem_if.mem_address,
    store_value: mem_if.mem_store_value,
    rob_index:   mem_if.mem_ROB_index
  };

  assign mem_if.mem_ready = !w_full && !reset;
  assign w_push           = mem_if.mem_valid && mem_if.mem_ready;

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_next_state = StBusy;
      StBusy:  if (r_cnt == '0) w_next_state = StResp;
      StResp:  w_next_state = w_empty ? StIdle : StBusy;
      default: w_next_state = StIdle;
    endcase
  end

  always_comb begin
    w_pop       = 1'b0;
    w_access    = 1'b0;
    w_valid_out = 1'b0;
    unique case (r_state)
      StIdle: w_pop = !w_empty;
      StBusy: w_access = (r_cnt == '0);
      StResp: begin
        w_valid_out = 1'b1;
        w_pop       = !w_empty;
      end
      default: ;
    endcase
  end

  // Word accesses drop the two low address bits; the array index wraps naturally.
  assign w_byte_idx  = r_cur.addr[AW-1:0];
  assign w_word_base = r_cur.addr[AW-1:2];
  assign w_rd_byte   = r_mem[w_byte_idx];
  assign w_rd_word   = {r_mem[{w_word_base, 2'd3}], r_mem[{w_word_base, 2'd2}],
                        r_mem[{w_word_base, 2'd1}], r_mem[{w_word_base, 2'd0}]};

  always_comb begin
    w_load_value = '0;
    if (r_cur.ls == LS_LOAD) begin
      w_load_value = (r_cur.bms == BMS_BYTE) ? sext_byte(w_rd_byte) : w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && (r_cur.ls == LS_STORE)) begin
      if (r_cur.bms == BMS_WORD) begin
        r_mem[{w_word_base, 2'd0}] <= r_cur.store_value[7:0];
        r_mem[{w_word_base, 2'd1}] <= r_cur.store_value[15:8];
        r_mem[{w_word_base, 2'd2}] <= r_cur.store_value[23:16];
        r_mem[{w_word_base, 2'd3}] <= r_cur.store_value[31:24];
      end else begin
        r_mem[w_byte_idx] <= r_cur.store_value[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_ls_out   <= 1'b0;
      r_addr_out <= '0;
      r_load_out <= '0;
      r_rob_out  <= '0;
    end else begin
      if (w_pop) begin
        r_cur <= w_head;
        r_cnt <= CntLoad;
      end else if ((r_state == StBusy) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_access) begin
        r_ls_out   <= r_cur.ls;
        r_addr_out <= r_cur.addr;
        r_load_out <= w_load_value;
        r_rob_out  <= r_cur.rob_index;
      end
    end
  end

  assign mem_if.mem_valid_out      = w_valid_out;
  assign mem_if.mem_LS_out         = r_ls_out;
  assign mem_if.mem_addr_out       = r_addr_out;
  assign mem_if.mem_load_value_out = r_load_out;
  assign mem_if.mem_ROB_index_out  = r_rob_out;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model predicts
// each response and its cycle; a negedge monitor checks every pulse and held output.
module tb_data_mem_responder;
  import lsq_mem_pkg::*;

  localparam int unsigned MB  = 1024;
  localparam int unsigned LAT = 4;
  localparam int unsigned FD  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .MEM_BYTES   (MB),
    .MEM_LATENCY (LAT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (bus)
  );

  typedef struct {
    logic        ls;
    logic [31:0] addr;
    logic [31:0] val;
    logic [5:0]  rob;
    int unsigned resp_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  model_mem [MB];
  logic [7:0]  snap_mem [MB];
  int unsigned cyc = 0;
  int unsigned last_exp = 0;
  int          errors = 0;
  int          checks = 0;

  logic        last_ls = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_val = '0;
  logic [5:0]  last_rob = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endfunction

  // Reference semantics: address mod MB, word base aligned down, little-endian,
  // sign-extended byte loads, stores return 0.
  function automatic logic [31:0] model_op(input logic ls, input logic bms,
                                           input logic [31:0] addr, input logic [31:0] sv);
    int unsigned a;
    int unsigned w;
    logic [31:0] r;
    a = addr % MB;
    w = a - (a % 4);
    r = '0;
    if (ls == LS_LOAD) begin
      if (bms == BMS_BYTE) begin
        r = {24'h0, model_mem[a]};
        if (model_mem[a] >= 8'h80) r = r | 32'hFFFF_FF00;
      end else begin
        r = {model_mem[w+3], model_mem[w+2], model_mem[w+1], model_mem[w]};
      end
    end else if (bms == BMS_BYTE) begin
      model_mem[a] = sv[7:0];
    end else begin
      for (int k = 0; k < 4; k++) model_mem[w+k] = sv[8*k +: 8];
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic ls, input logic bms, input logic [31:0] addr,
                      input logic [31:0] sv, input logic [5:0] rob,
                      input logic use_exp, input logic [31:0] exp_val);
    int unsigned tries;
    exp_t        e;
    logic [31:0] mv;
    tries = 0;
    bus.mem_valid       = 1'b1;
    bus.mem_LS          = ls;
    bus.mem_BMS         = bms;
    bus.mem_address     = addr;
    bus.mem_store_value = sv;
    bus.mem_ROB_index   = rob;
    while (!bus.mem_ready && tries < 200) begin
      @(posedge clk);
      #1;
      tries++;
    end
    chk("accept_ready", 32'(bus.mem_ready), 32'd1);
    if (!bus.mem_ready) begin
      bus.mem_valid = 1'b0;
      return;
    end
    mv         = model_op(ls, bms, addr, sv);
    e.ls       = ls;
    e.addr     = addr;
    e.val      = use_exp ? exp_val : mv;
    e.rob      = rob;
    e.resp_cyc = cyc + 1 + LAT + 1;
    if (last_exp + LAT + 1 > e.resp_cyc) e.resp_cyc = last_exp + LAT + 1;
    last_exp = e.resp_cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_ls   = 1'b0;
      last_addr = '0;
      last_val  = '0;
      last_rob  = '0;
    end else if (bus.mem_valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rob=%0d addr=0x%08h required no pulse",
                 bus.mem_ROB_index_out, bus.mem_addr_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_ls", 32'(bus.mem_LS_out), 32'(mon_e.ls));
        chk("resp_addr", bus.mem_addr_out, mon_e.addr);
        chk("resp_value", bus.mem_load_value_out, mon_e.val);
        chk("resp_rob", 32'(bus.mem_ROB_index_out), 32'(mon_e.rob));
        chk("resp_cycle", cyc, mon_e.resp_cyc);
        last_ls   = mon_e.ls;
        last_addr = mon_e.addr;
        last_val  = mon_e.val;
        last_rob  = mon_e.rob;
      end
    end else begin
      chk("hold_ls", 32'(bus.mem_LS_out), 32'(last_ls));
      chk("hold_addr", bus.mem_addr_out, last_addr);
      chk("hold_value", bus.mem_load_value_out, last_val);
      chk("hold_rob", 32'(bus.mem_ROB_index_out), 32'(last_rob));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic        rls;
    logic        rbms;
    int unsigned gap;

    for (int i = 0; i < int'(MB); i++) model_mem[i] = 8'h00;
    bus.mem_valid       = 1'b0;
    bus.mem_LS          = 1'b0;
    bus.mem_BMS         = 1'b0;
    bus.mem_address     = '0;
    bus.mem_store_value = '0;
    bus.mem_ROB_index   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_valid_out", 32'(bus.mem_valid_out), 32'd0);
    chk("rst_addr_out", bus.mem_addr_out, 32'd0);
    chk("rst_value_out", bus.mem_load_value_out, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.mem_ready), 32'd1);
    @(posedge clk);
    #1;

    // Zero the low region used by the directed and random phases.
    for (int i = 0; i < 32; i++) send(LS_STORE, BMS_WORD, 32'(i * 4), 32'd0, 6'(i), 1'b0, 32'd0);
    drain();

    // Store then load of the same word.
    send(LS_STORE, BMS_WORD, 32'h10, 32'hDEAD_BEEF, 6'd3, 1'b1, 32'd0);
    send(LS_LOAD, BMS_WORD, 32'h10, 32'd0, 6'd4, 1'b1, 32'hDEAD_BEEF);
    drain();

    // Byte store, sign-extended byte load, little-endian word load.
    send(LS_STORE, BMS_BYTE, 32'h15, 32'h80, 6'd5, 1'b1, 32'd0);
    send(LS_LOAD, BMS_BYTE, 32'h15, 32'd0, 6'd6, 1'b1, 32'hFFFF_FF80);
    send(LS_LOAD, BMS_WORD, 32'h14, 32'd0, 6'd7, 1'b1, 32'h0000_8000);
    drain();

    // Five back-to-back requests fill the buffer behind the one in service.
    send(LS_STORE, BMS_WORD, 32'h40, 32'h0102_0304, 6'd10, 1'b1, 32'd0);
    send(LS_LOAD, BMS_WORD, 32'h40, 32'd0, 6'd11, 1'b1, 32'h0102_0304);
    send(LS_STORE, BMS_BYTE, 32'h41, 32'h5555_55AA, 6'd12, 1'b1, 32'd0);
    send(LS_LOAD, BMS_BYTE, 32'h41, 32'd0, 6'd13, 1'b1, 32'hFFFF_FFAA);
    chk("ready_before_full", 32'(bus.mem_ready), 32'd1);
    send(LS_LOAD, BMS_WORD, 32'h42, 32'd0, 6'd14, 1'b1, 32'h0102_AA04);
    chk("ready_full", 32'(bus.mem_ready), 32'd0);
    drain();
    chk("ready_drained", 32'(bus.mem_ready), 32'd1);

    // Address wrap-around.
    send(LS_STORE, BMS_WORD, 32'h7FC, 32'h1234_5678, 6'd20, 1'b1, 32'd0);
    send(LS_LOAD, BMS_WORD, 32'h3FC, 32'd0, 6'd21, 1'b1, 32'h1234_5678);
    send(LS_LOAD, BMS_WORD, 32'h7FC, 32'd0, 6'd22, 1'b1, 32'h1234_5678);
    drain();

    // Reset two cycles after a store is accepted drops it with no response.
    send(LS_STORE, BMS_WORD, 32'h20, 32'h1122_3344, 6'd23, 1'b1, 32'd0);
    drain();
    snap_mem = model_mem;
    send(LS_STORE, BMS_WORD, 32'h20, 32'hCAFE_F00D, 6'd24, 1'b1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    model_mem = snap_mem;
    last_exp  = 0;
    @(posedge clk);
    #1;
    chk("midrst_ready", 32'(bus.mem_ready), 32'd0);
    chk("midrst_valid_out", 32'(bus.mem_valid_out), 32'd0);
    chk("midrst_addr_out", bus.mem_addr_out, 32'd0);
    chk("midrst_rob_out", 32'(bus.mem_ROB_index_out), 32'd0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(LS_LOAD, BMS_WORD, 32'h20, 32'd0, 6'd25, 1'b1, 32'h1122_3344);
    drain();

    // Single load from idle.
    send(LS_LOAD, BMS_WORD, 32'h10, 32'd0, 6'd30, 1'b1, 32'hDEAD_BEEF);
    drain();

    // Randomized traffic against the reference model, with aliased high addresses.
    for (int i = 0; i < 150; i++) begin
      ra = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) ra = ra | ($urandom() & 32'hFFFF_FC00);
      rls  = 1'($urandom_range(0, 1));
      rbms = 1'($urandom_range(0, 1));
      send(rls, rbms, ra, $urandom(), 6'(i), 1'b0, 32'd0);
      gap = $urandom_range(0, 6);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
